ctrl_rd_bram: RTL and testbench

Read-back counterpart of the BRAM write controller. It reads 32-bit words from either the IMAGE or the SECRET BRAM and unpacks each word into bytes, least-significant byte first. Each byte is pushed into an output byte FIFO until data_size bytes have been sent. It sits between the BRAM ports and the output FIFO feeding the stream/DMA path.

---
 rtl/ctrl_rd_bram_if.sv | 61 ++++++
 rtl/ctrl_rd_bram.sv | 205 ++++++++++++++++++++
 tb/tb_ctrl_rd_bram.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_rd_bram_if.sv
// Bus bundle for the BRAM read-back controller: register-bank control,
// the two BRAM read ports and the output byte FIFO write port.
interface ctrl_rd_bram_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_BYTES  = 4,
    parameter int REG_WIDTH  = 32,
    parameter int FF_WIDTH   = 8
) ();
    // register bank side
    logic                  start;
    logic [REG_WIDTH-1:0]  data_size;
    logic                  sel;
    logic                  busy;
    logic                  finish;

    // IMAGE BRAM port
    logic                  image_clk;
    logic [ADDR_WIDTH-1:0] image_addr;
    logic                  image_en;
    logic [NUM_BYTES-1:0]  image_we;
    logic [DATA_WIDTH-1:0] image_wrdata;
    logic [DATA_WIDTH-1:0] image_rddata;

    // SECRET BRAM port
    logic                  secret_clk;
    logic [ADDR_WIDTH-1:0] secret_addr;
    logic                  secret_en;
    logic [NUM_BYTES-1:0]  secret_we;
    logic [DATA_WIDTH-1:0] secret_wrdata;
    logic [DATA_WIDTH-1:0] secret_rddata;

    // output byte FIFO
    logic                  ff_full;
    logic [FF_WIDTH-1:0]   ff_wr_data;
    logic                  ff_wren;

    // environment / register bank / BRAMs / FIFO side
    modport master (
        output start, data_size, sel,
        input  busy, finish,
        input  image_clk, image_addr, image_en, image_we, image_wrdata,
        output image_rddata,
        input  secret_clk, secret_addr, secret_en, secret_we, secret_wrdata,
        output secret_rddata,
        output ff_full,
        input  ff_wr_data, ff_wren
    );

    // controller side
    modport slave (
        input  start, data_size, sel,
        output busy, finish,
        output image_clk, image_addr, image_en, image_we, image_wrdata,
        input  image_rddata,
        output secret_clk, secret_addr, secret_en, secret_we, secret_wrdata,
        input  secret_rddata,
        input  ff_full,
        output ff_wr_data, ff_wren
    );
endinterface

// File: rtl/ctrl_rd_bram.sv
// BRAM read-back controller: fetches 32-bit words from the IMAGE or SECRET
// BRAM and pushes them into the output byte FIFO, least-significant byte
// first, until data_size bytes have been written. At most one FIFO write
// every two cycles so ff_full is always sampled after the previous write.
module ctrl_rd_bram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_BYTES  = 4,
    parameter int REG_WIDTH  = 32,
    parameter int FF_WIDTH   = 8,
    parameter int RD_LAT     = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    ctrl_rd_bram_if.slave bus
);
    // word index addresses whole 4-byte words; it wraps silently
    localparam int IDX_WIDTH = ADDR_WIDTH - 2;
    localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_SEND,
        S_PUSH,
        S_FINISH
    } state_t;

    state_t                state_reg, state_next;
    logic                  sel_reg, sel_next;
    logic [REG_WIDTH-1:0]  size_reg, size_next;
    logic [DATA_WIDTH-1:0] word_reg, word_next;
    logic [REG_WIDTH-1:0]  byte_cnt_reg, byte_cnt_next;
    logic [IDX_WIDTH-1:0]  word_idx_reg, word_idx_next;
    logic [1:0]            byte_sel_reg, byte_sel_next;
    logic [1:0]            wait_cnt_reg, wait_cnt_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic                  img_en_reg, img_en_next;
    logic                  sec_en_reg, sec_en_next;
    logic                  ff_wren_reg, ff_wren_next;
    logic [FF_WIDTH-1:0]   ff_data_reg, ff_data_next;
    logic                  busy_reg, busy_next;
    logic                  finish_reg, finish_next;

    logic [REG_WIDTH-1:0]  byte_cnt_inc;
    logic [IDX_WIDTH-1:0]  word_idx_inc;
    logic [FF_WIDTH-1:0]   word_bytes [4];

    assign byte_cnt_inc = byte_cnt_reg + REG_WIDTH'(1);
    assign word_idx_inc = word_idx_reg + IDX_WIDTH'(1);

    // split the captured word into byte lanes, lane 0 = least significant
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign word_bytes[gi] = word_reg[gi*FF_WIDTH +: FF_WIDTH];
        end
    endgenerate

    // state and registered outputs; reset aborts any transfer in progress
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            sel_reg      <= 1'b0;
            size_reg     <= '0;
            word_reg     <= '0;
            byte_cnt_reg <= '0;
            word_idx_reg <= '0;
            byte_sel_reg <= '0;
            wait_cnt_reg <= '0;
            addr_reg     <= '0;
            img_en_reg   <= 1'b0;
            sec_en_reg   <= 1'b0;
            ff_wren_reg  <= 1'b0;
            ff_data_reg  <= '0;
            busy_reg     <= 1'b0;
            finish_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            sel_reg      <= sel_next;
            size_reg     <= size_next;
            word_reg     <= word_next;
            byte_cnt_reg <= byte_cnt_next;
            word_idx_reg <= word_idx_next;
            byte_sel_reg <= byte_sel_next;
            wait_cnt_reg <= wait_cnt_next;
            addr_reg     <= addr_next;
            img_en_reg   <= img_en_next;
            sec_en_reg   <= sec_en_next;
            ff_wren_reg  <= ff_wren_next;
            ff_data_reg  <= ff_data_next;
            busy_reg     <= busy_next;
            finish_reg   <= finish_next;
        end
    end

    // next state plus next values of every registered output; enables and
    // the FIFO strobe are single-cycle pulses so they default to 0
    always_comb begin
        state_next    = state_reg;
        sel_next      = sel_reg;
        size_next     = size_reg;
        word_next     = word_reg;
        byte_cnt_next = byte_cnt_reg;
        word_idx_next = word_idx_reg;
        byte_sel_next = byte_sel_reg;
        wait_cnt_next = wait_cnt_reg;
        addr_next     = addr_reg;
        img_en_next   = 1'b0;
        sec_en_next   = 1'b0;
        ff_wren_next  = 1'b0;
        ff_data_next  = ff_data_reg;
        busy_next     = busy_reg;
        finish_next   = finish_reg;

        case (state_reg)
            S_IDLE: begin
                sel_next  = bus.sel;
                size_next = bus.data_size;
                if (bus.start && (bus.data_size != '0)) begin
                    // enable is raised on entry so it is visible during ISSUE
                    state_next  = S_ISSUE;
                    addr_next   = {word_idx_reg, 2'b00};
                    img_en_next = ~bus.sel;
                    sec_en_next = bus.sel;
                    busy_next   = 1'b1;
                end
            end

            S_ISSUE: begin
                wait_cnt_next = '0;
                state_next    = S_WAIT;
            end

            S_WAIT: begin
                if (wait_cnt_reg == WAIT_LAST) begin
                    word_next  = sel_reg ? bus.secret_rddata : bus.image_rddata;
                    state_next = S_SEND;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 2'd1;
                end
            end

            S_SEND: begin
                if (!bus.ff_full) begin
                    ff_wren_next = 1'b1;
                    ff_data_next = word_bytes[byte_sel_reg];
                    state_next   = S_PUSH;
                end
            end

            S_PUSH: begin
                byte_cnt_next = byte_cnt_inc;
                byte_sel_next = byte_sel_reg + 2'd1;
                if (byte_cnt_inc == size_reg) begin
                    state_next  = S_FINISH;
                    finish_next = 1'b1;
                    busy_next   = 1'b0;
                end else if (byte_sel_reg == 2'd3) begin
                    word_idx_next = word_idx_inc;
                    addr_next     = {word_idx_inc, 2'b00};
                    img_en_next   = ~sel_reg;
                    sec_en_next   = sel_reg;
                    state_next    = S_ISSUE;
                end else begin
                    state_next = S_SEND;
                end
            end

            S_FINISH: begin
                if (!bus.start) begin
                    byte_cnt_next = '0;
                    word_idx_next = '0;
                    byte_sel_next = '0;
                    finish_next   = 1'b0;
                    state_next    = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign bus.busy          = busy_reg;
    assign bus.finish        = finish_reg;

    // shared address bus, per-BRAM enables, write side unused
    assign bus.image_clk     = clk;
    assign bus.image_addr    = addr_reg;
    assign bus.image_en      = img_en_reg;
    assign bus.image_we      = '0;
    assign bus.image_wrdata  = '0;

    assign bus.secret_clk    = clk;
    assign bus.secret_addr   = addr_reg;
    assign bus.secret_en     = sec_en_reg;
    assign bus.secret_we     = '0;
    assign bus.secret_wrdata = '0;

    assign bus.ff_wr_data    = ff_data_reg;
    assign bus.ff_wren       = ff_wren_reg;
endmodule

// File: tb/tb_ctrl_rd_bram.sv
// Bench for ctrl_rd_bram: two controllers (read latency 1 and 2) share the
// same stimulus; each has its own BRAM model and is checked by a monitor
// against a byte-stream model built from memory contents.
module tb_ctrl_rd_bram;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NB = 4;
    localparam int RW = 32;
    localparam int FW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          start;
    logic [RW-1:0] data_size;
    logic          sel;
    logic          ff_full;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ctrl_rd_bram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BYTES(NB),
                      .REG_WIDTH(RW), .FF_WIDTH(FW)) bus0 ();
    ctrl_rd_bram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BYTES(NB),
                      .REG_WIDTH(RW), .FF_WIDTH(FW)) bus1 ();

    ctrl_rd_bram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BYTES(NB),
                   .REG_WIDTH(RW), .FF_WIDTH(FW), .RD_LAT(1))
        u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    ctrl_rd_bram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BYTES(NB),
                   .REG_WIDTH(RW), .FF_WIDTH(FW), .RD_LAT(2))
        u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    assign bus0.start = start;  assign bus1.start = start;
    assign bus0.data_size = data_size;  assign bus1.data_size = data_size;
    assign bus0.sel = sel;  assign bus1.sel = sel;
    assign bus0.ff_full = ff_full;  assign bus1.ff_full = ff_full;

    // BRAM contents and models with 1- and 2-cycle read latency
    logic [31:0] img_mem [0:63];
    logic [31:0] sec_mem [0:63];
    logic [31:0] img_q0 = '0, sec_q0 = '0, img_p1 = '0, sec_p1 = '0, img_q1 = '0, sec_q1 = '0;

    always @(posedge clk) begin
        if (bus0.image_en)  img_q0 <= img_mem[bus0.image_addr[7:2]];
        if (bus0.secret_en) sec_q0 <= sec_mem[bus0.secret_addr[7:2]];
        if (bus1.image_en)  img_p1 <= img_mem[bus1.image_addr[7:2]];
        if (bus1.secret_en) sec_p1 <= sec_mem[bus1.secret_addr[7:2]];
        img_q1 <= img_p1;
        sec_q1 <= sec_p1;
    end
    assign bus0.image_rddata = img_q0;  assign bus0.secret_rddata = sec_q0;
    assign bus1.image_rddata = img_q1;  assign bus1.secret_rddata = sec_q1;

    // per-instance views for the monitor
    logic [1:0]  mon_wren, mon_ien, mon_sen;
    logic [7:0]  mon_data [2];
    logic [31:0] mon_addr [2];
    assign mon_wren = {bus1.ff_wren, bus0.ff_wren};
    assign mon_ien  = {bus1.image_en, bus0.image_en};
    assign mon_sen  = {bus1.secret_en, bus0.secret_en};
    assign mon_data[0] = bus0.ff_wr_data;  assign mon_data[1] = bus1.ff_wr_data;
    assign mon_addr[0] = bus0.image_addr;  assign mon_addr[1] = bus1.image_addr;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // expected byte streams and per-transfer observations
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int wr_cnt [2], ien_cnt [2], sen_cnt [2], last_wr_cyc [2];
    bit prev_wren [2];
    bit prev_full = 1'b0;
    bit nobp = 1'b0;
    int start_cyc = 0;
    int lat [2] = '{1, 2};

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mon_ien[k] || mon_sen[k]) begin
                check($sformatf("addr[%0d]", k), mon_addr[k], (ien_cnt[k] + sen_cnt[k]) * 4);
                if (mon_ien[k]) ien_cnt[k]++;
                if (mon_sen[k]) sen_cnt[k]++;
            end
            if (mon_wren[k]) begin
                logic [7:0] exp_b;
                bit have;
                have = 1'b0;
                exp_b = '0;
                if (k == 0 && q0.size() > 0) begin exp_b = q0.pop_front(); have = 1'b1; end
                if (k == 1 && q1.size() > 0) begin exp_b = q1.pop_front(); have = 1'b1; end
                check($sformatf("write_expected[%0d]", k), have, 1);
                if (have) check($sformatf("byte[%0d] #%0d", k, wr_cnt[k]), mon_data[k], exp_b);
                check($sformatf("write_while_full[%0d]", k), prev_full, 0);
                check($sformatf("back_to_back[%0d]", k), prev_wren[k], 0);
                if (nobp) begin
                    if (wr_cnt[k] == 0)
                        check($sformatf("first_latency[%0d]", k), cyc - start_cyc, lat[k] + 3);
                    else
                        check($sformatf("spacing[%0d] #%0d", k, wr_cnt[k]), cyc - last_wr_cyc[k],
                              (wr_cnt[k] % 4 == 0) ? lat[k] + 3 : 2);
                end
                last_wr_cyc[k] = cyc;
                wr_cnt[k]++;
            end
            prev_wren[k] = mon_wren[k];
        end
        prev_full = ff_full;
    end

    // build the expected byte stream from memory and launch a transfer
    task automatic begin_xfer(input bit s, input int size, input int mode);
        logic [31:0] w;
        q0.delete();
        q1.delete();
        for (int i = 0; i < size; i++) begin
            w = s ? sec_mem[i / 4] : img_mem[i / 4];
            q0.push_back(8'(w >> (8 * (i % 4))));
            q1.push_back(8'(w >> (8 * (i % 4))));
        end
        for (int k = 0; k < 2; k++) begin
            wr_cnt[k] = 0; ien_cnt[k] = 0; sen_cnt[k] = 0;
        end
        nobp = (mode == 0);
        ff_full = 1'b0;
        sel = s;
        data_size = RW'(size);
        start = 1'b1;
        start_cyc = cyc;
    endtask

    task automatic run_xfer(input bit s, input int size, input int mode, input int exp_en);
        int n, full_left;
        bit full_done;
        n = 0; full_left = 0; full_done = 1'b0;
        begin_xfer(s, size, mode);
        while (!(bus0.finish && bus1.finish) && n < 3000) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) check("busy_after_start", {bus1.busy, bus0.busy}, 2'b11);
            sel = 1'($urandom);
            data_size = RW'($urandom_range(0, 40));
            if (mode == 1) begin
                ff_full = ($urandom_range(0, 2) == 0);
            end else if (mode == 2) begin
                if (!full_done && wr_cnt[0] >= 1) begin
                    ff_full = 1'b1; full_left = 10; full_done = 1'b1;
                end
                if (full_left > 0) begin
                    full_left--;
                    if (full_left == 0) ff_full = 1'b0;
                end
            end
        end
        ff_full = 1'b0;
        check("finished_in_time", bus0.finish && bus1.finish, 1);
        check("writes[0]", wr_cnt[0], size);
        check("writes[1]", wr_cnt[1], size);
        check("leftover", q0.size() + q1.size(), 0);
        check("sel_en[0]", s ? sen_cnt[0] : ien_cnt[0], exp_en);
        check("sel_en[1]", s ? sen_cnt[1] : ien_cnt[1], exp_en);
        check("other_en", s ? ien_cnt[0] + ien_cnt[1] : sen_cnt[0] + sen_cnt[1], 0);
        repeat (3) begin @(posedge clk); #1; end
        check("finish_held", {bus1.finish, bus0.finish, bus1.busy, bus0.busy}, 4'b1100);
        start = 1'b0;
        @(posedge clk); #1;
        check("finish_cleared", {bus1.finish, bus0.finish, bus1.busy, bus0.busy}, 4'b0000);
        @(posedge clk); #1;
        $display("[TB] xfer sel=%0d size=%0d mode=%0d done, writes %0d/%0d", s, size, mode, wr_cnt[0], wr_cnt[1]);
    endtask

    typedef struct {
        bit sel;
        int size;
        int mode;    // 0 no backpressure, 1 random ff_full, 2 full 10 cycles after byte 1
        int exp_en;  // expected enable pulses on the selected BRAM
    } vec_t;

    vec_t vecs [8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, saved, sz;
        bit s;
        for (int i = 0; i < 64; i++) begin
            img_mem[i] = $urandom;
            sec_mem[i] = $urandom;
        end
        img_mem[0] = 32'h44332211;
        sec_mem[0] = 32'hDDCCBBAA;
        sec_mem[1] = 32'h00000055;

        vecs[0] = '{1'b0, 4, 0, 1};
        vecs[1] = '{1'b1, 5, 0, 2};
        vecs[2] = '{1'b0, 3, 2, 1};
        vecs[3] = '{1'b1, 8, 0, 2};
        vecs[4] = '{1'b0, 1, 0, 1};
        vecs[5] = '{1'b1, 7, 1, 2};
        vecs[6] = '{1'b0, 12, 1, 3};
        vecs[7] = '{1'b1, 16, 0, 4};

        rst_n = 1'b0; start = 1'b0; data_size = '0; sel = 1'b0; ff_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", {bus0.busy, bus0.finish, bus1.busy, bus1.finish}, 0);
        check("rst_en", {mon_ien, mon_sen, mon_wren}, 0);
        check("rst_addr", bus0.image_addr | bus0.secret_addr | bus1.image_addr | bus1.secret_addr, 0);
        check("rst_ffdata", {bus0.ff_wr_data, bus1.ff_wr_data}, 0);
        check("tied_we", {bus0.image_we, bus0.secret_we, bus1.image_we, bus1.secret_we}, 0);
        check("tied_wrdata", bus0.image_wrdata | bus0.secret_wrdata | bus1.image_wrdata | bus1.secret_wrdata, 0);
        check("bram_clk", {bus0.image_clk, bus0.secret_clk}, {clk, clk});
        rst_n = 1'b1;
        @(posedge clk); #1;

        // table-driven transfers
        for (int v = 0; v < 8; v++)
            run_xfer(vecs[v].sel, vecs[v].size, vecs[v].mode, vecs[v].exp_en);

        // start with zero size is ignored
        for (int k = 0; k < 2; k++) begin ien_cnt[k] = 0; sen_cnt[k] = 0; end
        q0.delete(); q1.delete();
        start = 1'b1; data_size = '0; sel = 1'($urandom);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check($sformatf("zero_size_idle c%0d", i), {bus0.busy, bus0.finish, bus1.busy, bus1.finish}, 0);
        end
        check("zero_size_no_en", ien_cnt[0] + ien_cnt[1] + sen_cnt[0] + sen_cnt[1], 0);
        start = 1'b0;
        @(posedge clk); #1;
        $display("[TB] zero-size start ignored check done");

        // reset during SEND of byte 2 aborts, then a fresh transfer restarts at 0
        begin_xfer(1'b0, 8, 0);
        n = 0;
        while (wr_cnt[0] < 1 && n < 100) begin @(posedge clk); #1; n++; end
        check("abort_reached_byte2", wr_cnt[0], 1);
        rst_n = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        check("abort_ctrl", {bus0.busy, bus0.finish, bus1.busy, bus1.finish}, 0);
        check("abort_en_wren", {mon_ien, mon_sen, mon_wren}, 0);
        check("abort_addr_data", bus0.image_addr | bus1.image_addr | 32'(bus0.ff_wr_data) | 32'(bus1.ff_wr_data), 0);
        rst_n = 1'b1;
        q0.delete(); q1.delete();
        saved = wr_cnt[0] + wr_cnt[1];
        repeat (8) begin @(posedge clk); #1; end
        check("no_write_after_abort", wr_cnt[0] + wr_cnt[1], saved);
        $display("[TB] mid-transfer reset check done");
        run_xfer(1'b0, 8, 0, 2);

        // randomized transfers against the byte-stream model
        for (int r = 0; r < 12; r++) begin
            s = 1'($urandom);
            sz = $urandom_range(1, 20);
            run_xfer(s, sz, (r % 3 == 0) ? 0 : 1, (sz + 3) / 4);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
